// File: rtl/bytecode_fetch_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : bytecode_fetch_if
//  Purpose  : Request/delivery handshake and bytecode RAM port of the
//             bytecode fetch unit, bundled into one interface.
//  Revision : 1.0 - initial release
// ============================================================================
interface bytecode_fetch_if #(
  parameter int ADDRESS_WIDTH = 12
);
  logic                     pc_reset;
  logic                     start;
  logic [7:0]               next_byte;
  logic                     ready;
  logic                     eof;
  logic                     busy;
  logic [ADDRESS_WIDTH-1:0] pc;
  logic [ADDRESS_WIDTH-3:0] mem_addr;
  logic                     mem_rd;
  logic [31:0]              mem_rdata;

  // Environment side: the byte consumer plus the RAM that answers reads.
  modport master (
    output pc_reset, start, mem_rdata,
    input  next_byte, ready, eof, busy, pc, mem_addr, mem_rd
  );

  // Fetch unit side.
  modport slave (
    input  pc_reset, start, mem_rdata,
    output next_byte, ready, eof, busy, pc, mem_addr, mem_rd
  );
endinterface
`default_nettype wire

// File: rtl/bytecode_fetch.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : bytecode_fetch
//  Purpose  : Delivers one JVM bytecode byte per start/ready handshake from a
//             word-wide synchronous RAM through a one-word buffer, tracks the
//             bytecode PC and flags end of code.
//  Revision : 1.0 - initial release
// ============================================================================
module bytecode_fetch #(
  parameter int SIZE          = 1024,
  parameter int ADDRESS_WIDTH = 12
) (
  input  wire logic       clk,
  input  wire logic       rst_n,
  bytecode_fetch_if.slave bus
);

  localparam int                     c_WORD_W = ADDRESS_WIDTH - 2;
  localparam logic [ADDRESS_WIDTH:0] c_SIZE   = SIZE[ADDRESS_WIDTH:0];

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_READ = 2'd1;
  localparam logic [1:0] c_FILL = 2'd2;

  logic [1:0]               r_state;
  logic [1:0]               w_next_state;
  logic [ADDRESS_WIDTH-1:0] r_pc;
  logic [31:0]              r_buf_word;
  logic [c_WORD_W-1:0]      r_buf_tag;
  logic                     r_buf_valid;
  logic [7:0]               r_next_byte;
  logic                     r_ready;
  logic                     r_eof;
  logic [c_WORD_W-1:0]      r_mem_addr;

  logic [c_WORD_W-1:0]      w_word_addr;
  logic                     w_at_end;
  logic                     w_hit;
  logic                     w_accept;
  logic                     w_mem_rd;
  logic                     w_busy;
  logic [7:0]               w_buf_byte;
  logic [7:0]               w_mem_byte;

  // Big-endian byte lane select: offset 0 is the most significant byte.
  function automatic logic [7:0] sel_byte(input logic [31:0] word, input logic [1:0] ofs);
    logic [7:0] b;
    case (ofs)
      2'd0:    b = word[31:24];
      2'd1:    b = word[23:16];
      2'd2:    b = word[15:8];
      default: b = word[7:0];
    endcase
    return b;
  endfunction

  assign w_word_addr = r_pc[ADDRESS_WIDTH-1:2];
  assign w_at_end    = ({1'b0, r_pc} >= c_SIZE);
  assign w_hit       = r_buf_valid && (r_buf_tag == w_word_addr);
  assign w_accept    = (r_state == c_IDLE) && bus.start && !bus.pc_reset;
  assign w_buf_byte  = sel_byte(r_buf_word, r_pc[1:0]);
  assign w_mem_byte  = sel_byte(bus.mem_rdata, r_pc[1:0]);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next state: only a buffer miss leaves IDLE; pc_reset always returns to IDLE.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_IDLE:  if (w_accept && !w_at_end && !w_hit) w_next_state = c_READ;
      c_READ:  w_next_state = c_FILL;
      c_FILL:  w_next_state = c_IDLE;
      default: w_next_state = c_IDLE;
    endcase
    if (bus.pc_reset) begin
      w_next_state = c_IDLE;
    end
  end

  // State-decoded outputs: one-cycle RAM strobe in READ, busy across the fetch.
  always_comb begin
    w_mem_rd = 1'b0;
    w_busy   = 1'b0;
    case (r_state)
      c_READ: begin
        w_mem_rd = 1'b1;
        w_busy   = 1'b1;
      end
      c_FILL:  w_busy = 1'b1;
      default: ;
    endcase
  end

  // Datapath: PC, word buffer, delivered byte and the registered ready/eof pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc        <= '0;
      r_buf_word  <= '0;
      r_buf_tag   <= '0;
      r_buf_valid <= 1'b0;
      r_next_byte <= '0;
      r_ready     <= 1'b0;
      r_eof       <= 1'b0;
      r_mem_addr  <= '0;
    end else begin
      r_ready <= 1'b0;
      // Remember the word address driven during READ so it holds afterwards.
      if (r_state == c_READ) begin
        r_mem_addr <= w_word_addr;
      end
      if (bus.pc_reset) begin
        r_pc        <= '0;
        r_buf_valid <= 1'b0;
      end else if (w_accept) begin
        if (w_at_end) begin
          r_ready     <= 1'b1;
          r_eof       <= 1'b1;
          r_next_byte <= 8'h00;
        end else if (w_hit) begin
          r_ready     <= 1'b1;
          r_eof       <= 1'b0;
          r_next_byte <= w_buf_byte;
          r_pc        <= r_pc + ADDRESS_WIDTH'(1);
        end
      end else if (r_state == c_FILL) begin
        r_buf_word  <= bus.mem_rdata;
        r_buf_tag   <= w_word_addr;
        r_buf_valid <= 1'b1;
        r_ready     <= 1'b1;
        r_eof       <= 1'b0;
        r_next_byte <= w_mem_byte;
        r_pc        <= r_pc + ADDRESS_WIDTH'(1);
      end
    end
  end

  assign bus.next_byte = r_next_byte;
  assign bus.ready     = r_ready;
  assign bus.eof       = r_eof;
  assign bus.busy      = w_busy;
  assign bus.pc        = r_pc;
  assign bus.mem_rd    = w_mem_rd;
  assign bus.mem_addr  = w_mem_rd ? w_word_addr : r_mem_addr;

endmodule
`default_nettype wire

// File: tb/tb_bytecode_fetch.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_bytecode_fetch
//  Purpose  : Directed self-checking bench for bytecode_fetch. Instance A has
//             SIZE=8, instance B has SIZE=5; both read the same two-word RAM.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bytecode_fetch;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  int          rd_cnt_a, rd_cnt_b, rdy_cnt_a;
  logic [9:0]  last_addr_a;

  bytecode_fetch_if #(.ADDRESS_WIDTH(12)) if_a ();
  bytecode_fetch_if #(.ADDRESS_WIDTH(12)) if_b ();

  bytecode_fetch #(.SIZE(8), .ADDRESS_WIDTH(12)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_a.slave)
  );

  bytecode_fetch #(.SIZE(5), .ADDRESS_WIDTH(12)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [9:0] a);
    case (a)
      10'd0:   return 32'h102A60B1;
      10'd1:   return 32'hC4150003;
      default: return 32'h00000000;
    endcase
  endfunction

  // Synchronous RAM model, latency 1, plus strobe/ready counters.
  always @(posedge clk) begin
    if (if_a.mem_rd) begin
      if_a.mem_rdata <= rom(if_a.mem_addr);
      rd_cnt_a       <= rd_cnt_a + 1;
      last_addr_a    <= if_a.mem_addr;
    end
    if (if_b.mem_rd) begin
      if_b.mem_rdata <= rom(if_b.mem_addr);
      rd_cnt_b       <= rd_cnt_b + 1;
    end
    if (if_a.ready) rdy_cnt_a <= rdy_cnt_a + 1;
  end

  // One request: start high for one cycle, wait (bounded) for ready.
  // lat is the cycle number of ready relative to the request cycle, -1 on timeout.
  task automatic do_start(input bit which, output logic [7:0] b, output logic e, output int lat);
    lat = -1;
    b   = 8'hxx;
    e   = 1'bx;
    if (which) if_b.start = 1'b1; else if_a.start = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (i == 1) begin
        if_a.start = 1'b0;
        if_b.start = 1'b0;
      end
      if (which ? if_b.ready : if_a.ready) begin
        lat = i;
        b   = which ? if_b.next_byte : if_a.next_byte;
        e   = which ? if_b.eof : if_a.eof;
        break;
      end
    end
  endtask

  task automatic pulse_pc_reset_a();
    if_a.pc_reset = 1'b1;
    @(negedge clk);
    if_a.pc_reset = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({if_a.next_byte, if_a.ready, if_a.eof, if_a.busy, if_a.pc, if_a.mem_addr, if_a.mem_rd} !== '0) begin
      errors++;
      $display("FAIL reset_outputs_a: got nb=%h rdy=%b eof=%b busy=%b pc=%0d addr=%0d rd=%b, expected all zero",
               if_a.next_byte, if_a.ready, if_a.eof, if_a.busy, if_a.pc, if_a.mem_addr, if_a.mem_rd);
    end
    checks++;
    if ({if_b.next_byte, if_b.ready, if_b.eof, if_b.busy, if_b.pc, if_b.mem_addr, if_b.mem_rd} !== '0) begin
      errors++;
      $display("FAIL reset_outputs_b: got nonzero outputs pc=%0d busy=%b, expected all zero", if_b.pc, if_b.busy);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({if_a.ready, if_a.busy, if_a.mem_rd} !== 3'b000) begin
      errors++;
      $display("FAIL idle_after_reset: got rdy/busy/rd=%b, expected 000", {if_a.ready, if_a.busy, if_a.mem_rd});
    end
  endtask

  task automatic test_hit_miss();
    logic [7:0] exp [4] = '{8'h10, 8'h2A, 8'h60, 8'hB1};
    logic [7:0] b;
    logic       e;
    int         lat;
    int         rd0 = rd_cnt_a;
    for (int i = 0; i < 4; i++) begin
      do_start(1'b0, b, e, lat);
      checks++;
      if (b !== exp[i] || e !== 1'b0) begin
        errors++;
        $display("FAIL hm_byte%0d: got %h eof=%b, expected %h eof=0", i, b, e, exp[i]);
      end
      checks++;
      if (lat != ((i == 0) ? 3 : 1)) begin
        errors++;
        $display("FAIL hm_latency%0d: got %0d, expected %0d", i, lat, (i == 0) ? 3 : 1);
      end
    end
    checks++;
    if (rd_cnt_a - rd0 != 1 || last_addr_a !== 10'd0) begin
      errors++;
      $display("FAIL hm_reads: got %0d reads last addr %0d, expected 1 read at addr 0", rd_cnt_a - rd0, last_addr_a);
    end
    checks++;
    if (if_a.pc !== 12'd4) begin
      errors++;
      $display("FAIL hm_pc: got %0d, expected 4", if_a.pc);
    end
  endtask

  task automatic test_word_boundary();
    logic [7:0] b;
    logic       e;
    int         lat;
    int         rd0 = rd_cnt_a;
    do_start(1'b0, b, e, lat);
    checks++;
    if (b !== 8'hC4 || lat != 3) begin
      errors++;
      $display("FAIL wb_miss: got byte %h at %0d, expected C4 at 3", b, lat);
    end
    checks++;
    if (rd_cnt_a - rd0 != 1 || last_addr_a !== 10'd1) begin
      errors++;
      $display("FAIL wb_read: got %0d reads last addr %0d, expected 1 read at addr 1", rd_cnt_a - rd0, last_addr_a);
    end
    do_start(1'b0, b, e, lat);
    checks++;
    if (b !== 8'h15 || lat != 1) begin
      errors++;
      $display("FAIL wb_hit: got byte %h at %0d, expected 15 at 1", b, lat);
    end
    checks++;
    if (if_a.pc !== 12'd6) begin
      errors++;
      $display("FAIL wb_pc: got %0d, expected 6", if_a.pc);
    end
  endtask

  task automatic test_eof();
    logic [7:0] exp [5] = '{8'h10, 8'h2A, 8'h60, 8'hB1, 8'hC4};
    logic [7:0] b;
    logic       e;
    int         lat;
    int         rd0;
    for (int i = 0; i < 5; i++) begin
      do_start(1'b1, b, e, lat);
      checks++;
      if (b !== exp[i] || e !== 1'b0) begin
        errors++;
        $display("FAIL eof_byte%0d: got %h eof=%b, expected %h eof=0", i, b, e, exp[i]);
      end
    end
    rd0 = rd_cnt_b;
    for (int k = 0; k < 2; k++) begin
      do_start(1'b1, b, e, lat);
      checks++;
      if (lat != 1 || e !== 1'b1 || b !== 8'h00) begin
        errors++;
        $display("FAIL eof_end%0d: got lat=%0d eof=%b byte=%h, expected lat=1 eof=1 byte=00", k, lat, e, b);
      end
      checks++;
      if (if_b.pc !== 12'd5) begin
        errors++;
        $display("FAIL eof_pc%0d: got %0d, expected 5", k, if_b.pc);
      end
    end
    checks++;
    if (rd_cnt_b != rd0) begin
      errors++;
      $display("FAIL eof_noread: got %0d reads, expected 0", rd_cnt_b - rd0);
    end
  endtask

  task automatic test_pc_reset_fill();
    logic [7:0] b;
    logic       e;
    int         lat;
    int         rdy0;
    int         rd0;
    pulse_pc_reset_a();
    checks++;
    if (if_a.pc !== 12'd0) begin
      errors++;
      $display("FAIL pcr_idle: got pc %0d, expected 0", if_a.pc);
    end
    rdy0 = rdy_cnt_a;
    if_a.start = 1'b1;
    @(negedge clk);                 // READ
    if_a.start = 1'b0;
    @(negedge clk);                 // FILL
    checks++;
    if (if_a.busy !== 1'b1 || if_a.mem_rd !== 1'b0) begin
      errors++;
      $display("FAIL pcr_infill: got busy=%b rd=%b, expected busy=1 rd=0", if_a.busy, if_a.mem_rd);
    end
    if_a.pc_reset = 1'b1;
    @(negedge clk);
    if_a.pc_reset = 1'b0;
    checks++;
    if (if_a.ready !== 1'b0 || if_a.pc !== 12'd0 || if_a.busy !== 1'b0) begin
      errors++;
      $display("FAIL pcr_abort: got rdy=%b pc=%0d busy=%b, expected 0 0 0", if_a.ready, if_a.pc, if_a.busy);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (rdy_cnt_a != rdy0) begin
      errors++;
      $display("FAIL pcr_noready: got %0d ready pulses, expected 0", rdy_cnt_a - rdy0);
    end
    rd0 = rd_cnt_a;
    do_start(1'b0, b, e, lat);
    checks++;
    if (b !== 8'h10 || lat != 3 || rd_cnt_a - rd0 != 1 || last_addr_a !== 10'd0) begin
      errors++;
      $display("FAIL pcr_refetch: got byte %h lat %0d reads %0d addr %0d, expected 10 3 1 0",
               b, lat, rd_cnt_a - rd0, last_addr_a);
    end
  endtask

  task automatic test_collisions();
    int rdy0;
    pulse_pc_reset_a();
    rdy0 = rdy_cnt_a;
    if_a.start = 1'b1;              // accepted, miss
    @(negedge clk);                 // READ: start still high, must be dropped
    @(negedge clk);                 // FILL
    if_a.start = 1'b0;
    @(negedge clk);
    checks++;
    if (if_a.ready !== 1'b1 || if_a.next_byte !== 8'h10) begin
      errors++;
      $display("FAIL col_deliver: got rdy=%b byte=%h, expected 1 10", if_a.ready, if_a.next_byte);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (rdy_cnt_a - rdy0 != 1 || if_a.pc !== 12'd1) begin
      errors++;
      $display("FAIL col_single: got %0d readies pc=%0d, expected 1 readies pc=1", rdy_cnt_a - rdy0, if_a.pc);
    end
    if_a.start    = 1'b1;
    if_a.pc_reset = 1'b1;
    @(negedge clk);
    if_a.start    = 1'b0;
    if_a.pc_reset = 1'b0;
    checks++;
    if (if_a.ready !== 1'b0 || if_a.pc !== 12'd0 || if_a.busy !== 1'b0) begin
      errors++;
      $display("FAIL col_pcr_start: got rdy=%b pc=%0d busy=%b, expected 0 0 0", if_a.ready, if_a.pc, if_a.busy);
    end
  endtask

  task automatic test_async_reset();
    logic [7:0] b;
    logic       e;
    int         lat;
    int         rd0;
    for (int i = 0; i < 4; i++) do_start(1'b0, b, e, lat);
    checks++;
    if (if_a.pc !== 12'd4) begin
      errors++;
      $display("FAIL ar_setup: got pc %0d, expected 4", if_a.pc);
    end
    if_a.start = 1'b1;
    @(negedge clk);
    if_a.start = 1'b0;
    checks++;
    if (if_a.mem_rd !== 1'b1 || if_a.busy !== 1'b1 || if_a.mem_addr !== 10'd1) begin
      errors++;
      $display("FAIL ar_read: got rd=%b busy=%b addr=%0d, expected 1 1 1", if_a.mem_rd, if_a.busy, if_a.mem_addr);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (if_a.mem_rd !== 1'b0 || if_a.busy !== 1'b0 || if_a.pc !== 12'd0 || if_a.mem_addr !== 10'd0) begin
      errors++;
      $display("FAIL ar_async: got rd=%b busy=%b pc=%0d addr=%0d, expected all 0",
               if_a.mem_rd, if_a.busy, if_a.pc, if_a.mem_addr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rd0 = rd_cnt_a;
    do_start(1'b0, b, e, lat);
    checks++;
    if (b !== 8'h10 || lat != 3 || rd_cnt_a - rd0 != 1) begin
      errors++;
      $display("FAIL ar_refetch: got byte %h lat %0d reads %0d, expected 10 3 1", b, lat, rd_cnt_a - rd0);
    end
  endtask

  initial begin
    errors        = 0;
    checks        = 0;
    rd_cnt_a      = 0;
    rd_cnt_b      = 0;
    rdy_cnt_a     = 0;
    if_a.start    = 1'b0;
    if_a.pc_reset = 1'b0;
    if_b.start    = 1'b0;
    if_b.pc_reset = 1'b0;
    rst_n         = 1'b0;
    test_reset();
    test_hit_miss();
    test_word_boundary();
    test_eof();
    test_pc_reset_fill();
    test_collisions();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/bytecode_fetch.md
# bytecode_fetch

Upstream byte source for the JVM-to-ARM translation state machine. Delivers one JVM bytecode byte per `start`/`ready` handshake: opcode, wide prefix, or operand byte. Reads 32-bit words from the bytecode RAM and holds the current word in a one-word buffer, so a RAM read is needed only when a fetch crosses into a new word. Tracks the bytecode PC and reports end of code.

## Interface
Parameters:
- `SIZE`, 1024: code length in bytes; the valid PC range is 0..SIZE-1.
- `ADDRESS_WIDTH`, 12: byte-address width, which is also the PC width. The word address is `ADDRESS_WIDTH-2` bits.

Ports:
- `clk` in 1: the single clock; all state changes on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `pc_reset` in 1: synchronous. Sets PC to 0, invalidates the buffer, aborts any fetch in flight.
- `start` in 1: single-cycle request for the next byte. Ignored unless the block is idle.
- `next_byte` out 8: fetched byte. Valid while `ready`=1 and held until the next delivery.
- `ready` out 1: one-cycle pulse marking delivery.
- `eof` out 1: valid with `ready`. Set to 1 when PC ≥ SIZE at the time of the request.
- `busy` out 1: high in READ and FILL.
- `pc` out ADDRESS_WIDTH: byte address of the next byte to deliver.
- `mem_addr` out ADDRESS_WIDTH-2: RAM word address.
- `mem_rd` out 1: RAM read strobe, one cycle.
- `mem_rdata` in 32: RAM data. Valid in the cycle after `mem_rd`, because the RAM reads synchronously with latency 1.

## Operation
Byte order within a word is big-endian, matching JVM order:
- `pc[1:0]`=0 selects `[31:24]`.
- `pc[1:0]`=3 selects `[7:0]`.

Buffer:
- `buf_word` 32 bits, `buf_tag` ADDRESS_WIDTH-2 bits, `buf_valid` 1 bit.
- Hit condition: `buf_valid` && `buf_tag`==`pc[ADDRESS_WIDTH-1:2]`.

States: IDLE, READ, FILL.

IDLE, with `start`=1 and `pc_reset`=0:
- PC ≥ SIZE: register `ready`=1, `eof`=1, `next_byte`=8'h00. PC unchanged. No RAM access. Stay in IDLE.
- Hit: register `ready`=1, `eof`=0, `next_byte`=selected buffer byte. PC ← PC+1. Stay in IDLE.
- Miss: go to READ.

READ:
- `mem_rd`=1 and `mem_addr`=`pc[ADDRESS_WIDTH-1:2]`, both driven combinationally from state.
- Next state is FILL.

FILL:
- Load `buf_word` ← `mem_rdata`, `buf_tag` ← word address, `buf_valid` ← 1.
- Register `ready`=1 and `next_byte`=the selected byte of `mem_rdata`.
- PC ← PC+1. Go to IDLE.

Other rules:
- `mem_addr` holds its last value outside READ. It is 0 after reset.
- PC increments by exactly 1 per non-eof delivery and saturates at SIZE; there is no wrap-around.
- The block never prefetches. The buffer is the only cache.

## Timing
- Request in cycle n. Hit or eof: `ready` high in cycle n+1. Miss: `mem_rd` high in n+1, `ready` high in n+3.
- `ready` is registered and high for exactly one cycle per accepted `start`.
- A new `start` may be issued in the same cycle that `ready` is high. It is accepted because the block is in IDLE.
- `start` in READ or FILL is dropped with no queueing. The requester must wait for `ready`.
- `pc_reset`:
  - Takes priority over a simultaneous `start`, which is dropped.
  - In READ or FILL it returns the block to IDLE, discards `mem_rdata`, and produces no `ready`.
  - Clears `buf_valid`.
- `rst_n` low, asynchronous, sets every output to 0 (`next_byte`, `ready`, `eof`, `busy`, `pc`, `mem_addr`, `mem_rd`), with state IDLE and `buf_valid`=0. This applies mid-fetch as well.
- Release of `rst_n` is synchronous to `clk`, provided externally.

## Test plan
- **Basic hit/miss latency.** SIZE=8, word0=32'h102A60B1. Reset, then 4 starts, each after `ready` → bytes 10, 2A, 60, B1. First `ready` at n+3; the rest at n+1. Exactly one `mem_rd`, with `mem_addr`=0. PC ends at 4.
- **Word boundary.** Continue with word1=32'hC4150003. 5th start → miss, `mem_rd` with `mem_addr`=1, byte C4 at n+3. 6th start → 15 at n+1.
- **End of code.** SIZE=5, after 5 bytes delivered, start → `ready` at n+1, `eof`=1, `next_byte`=00, PC stays 5, no `mem_rd`. Repeating the start gives the same result.
- **pc_reset in FILL.** Assert `pc_reset` in FILL → no `ready`, PC=0, `busy`=0 next cycle. Next start misses again (`mem_rd`, `mem_addr`=0) and returns byte 10.
- **Collisions.** `start` during READ → ignored, one `ready` only. `start` and `pc_reset` in the same idle cycle → no `ready`, PC=0.
- **Async reset.** Drop `rst_n` during READ → `mem_rd`, `busy` and PC go to 0 without waiting for a clock edge. After release, the first start misses.
